image_zero_sched: RTL and testbench



---
 rtl/image_zero_sched_pkg.sv | 12 +
 rtl/image_zero_loop_cnt.sv | 49 ++++
 rtl/image_zero_sched.sv | 111 +++++++++++
 tb/tb_image_zero_sched.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/image_zero_sched_pkg.sv
// Shared definitions for the zero-point/ReLU output-stage sequencer.
package image_zero_sched_pkg;
  localparam int PIPE_LAT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/image_zero_loop_cnt.sv
// Nested col/row/grp beat counter; col fastest. last flags the final beat of the tile.
module image_zero_loop_cnt #(
  parameter int COL_W = 12,
  parameter int ROW_W = 12,
  parameter int CH_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [COL_W-1:0] num_col,
  input  logic [ROW_W-1:0] num_row,
  input  logic [CH_W-1:0]  num_grp,
  output logic             last
);
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CH_W-1:0]  grp;
  logic             col_end, row_end, grp_end;

  assign col_end = (col == num_col - COL_W'(1));
  assign row_end = (row == num_row - ROW_W'(1));
  assign grp_end = (grp == num_grp - CH_W'(1));
  assign last    = col_end & row_end & grp_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      grp <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
      grp <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row <= '0;
          grp <= grp_end ? '0 : grp + CH_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end
endmodule

// File: rtl/image_zero_sched.sv
// Sequencer for the zero-point-add / ReLU stage: issues upstream pops, tracks the
// fixed-latency datapath with a valid/last delay line, drains, and pulses done per tile.
module image_zero_sched
  import image_zero_sched_pkg::*;
#(
  parameter int COL_W    = 12,
  parameter int ROW_W    = 12,
  parameter int CH_W     = 10,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cfg_zero,
  input  logic [COL_W-1:0] cfg_col,
  input  logic [ROW_W-1:0] cfg_row,
  input  logic [CH_W-1:0]  cfg_ch_grp,
  input  logic             src_empty,
  output logic             src_rd_en,
  output logic [7:0]       zero_data_out,
  input  logic             dst_almost_full,
  output logic             dst_wr_en,
  output logic             dst_last,
  output logic             busy,
  output logic             done
);
  state_e             state;
  logic [COL_W-1:0]   num_col;
  logic [ROW_W-1:0]   num_row;
  logic [CH_W-1:0]    num_grp;
  logic               issued_last;
  logic               cnt_last;
  logic               cfg_empty;
  logic               accept;
  logic [PIPE_LAT:1]  vld_pipe;
  logic [PIPE_LAT:1]  last_pipe;

  assign cfg_empty = (cfg_col == '0) || (cfg_row == '0) || (cfg_ch_grp == '0);
  assign accept    = (state == IDLE) && start;
  assign src_rd_en = (state == RUN) && !src_empty && !dst_almost_full && !issued_last;
  assign dst_wr_en = vld_pipe[PIPE_LAT];
  assign dst_last  = last_pipe[PIPE_LAT];

  image_zero_loop_cnt #(
    .COL_W(COL_W),
    .ROW_W(ROW_W),
    .CH_W (CH_W)
  ) u_loop_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (src_rd_en),
    .num_col(num_col),
    .num_row(num_row),
    .num_grp(num_grp),
    .last   (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[PIPE_LAT-1:1],  src_rd_en};
      last_pipe <= {last_pipe[PIPE_LAT-1:1], src_rd_en & cnt_last};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      num_col       <= '0;
      num_row       <= '0;
      num_grp       <= '0;
      zero_data_out <= '0;
      issued_last   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          num_col       <= cfg_col;
          num_row       <= cfg_row;
          num_grp       <= cfg_ch_grp;
          zero_data_out <= cfg_zero;
          issued_last   <= 1'b0;
          busy          <= 1'b1;
          state         <= cfg_empty ? DONE : LOAD;
          done          <= cfg_empty;
        end
        LOAD: state <= RUN;
        RUN: if (src_rd_en && cnt_last) begin
          issued_last <= 1'b1;
          state       <= DRAIN;
        end
        // Leave once only the output stage can still hold a beat, so the pipe is
        // empty in the DONE cycle and done lands right after the final write.
        DRAIN: if (~|vld_pipe[PIPE_LAT-1:1]) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_zero_sched.sv
// Directed bench for image_zero_sched: per-cycle compare against an event-time model
// plus literal expectations on beat counts and completion offsets.
module tb_image_zero_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_zero = '0;
  logic [11:0] cfg_col = '0;
  logic [11:0] cfg_row = '0;
  logic [9:0]  cfg_ch_grp = '0;
  logic        src_empty = 1'b0;
  logic        dst_almost_full = 1'b0;
  logic        src_rd_en, dst_wr_en, dst_last, busy, done;
  logic [7:0]  zero_data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  image_zero_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_zero       (cfg_zero),
    .cfg_col        (cfg_col),
    .cfg_row        (cfg_row),
    .cfg_ch_grp     (cfg_ch_grp),
    .src_empty      (src_empty),
    .src_rd_en      (src_rd_en),
    .zero_data_out  (zero_data_out),
    .dst_almost_full(dst_almost_full),
    .dst_wr_en      (dst_wr_en),
    .dst_last       (dst_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: a tile is described by its accept cycle, total beats and progress counts.
  bit         m_active = 0;
  int         t_start = 0, t_done = -1, m_total = 0, m_issued = 0, m_written = 0;
  logic [7:0] m_zero = '0;
  bit         h1 = 0, h2 = 0;

  always @(negedge clk) begin
    bit e_rd, e_wr, e_last, e_done, e_busy;
    if (!rst_n) begin
      m_active = 0; h1 = 0; h2 = 0; m_zero = '0; t_done = -1;
      chk("rst_rd_en", src_rd_en, 0);
      chk("rst_wr_en", dst_wr_en, 0);
      chk("rst_last",  dst_last, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_zero",  zero_data_out, 0);
    end else begin
      e_rd   = m_active && (cyc >= t_start + 2) && (m_issued < m_total)
               && !src_empty && !dst_almost_full;
      e_wr   = h2;
      e_last = e_wr && (m_written + 1 == m_total);
      e_done = m_active && (cyc == t_done);
      e_busy = m_active && (cyc > t_start);
      chk("src_rd_en", src_rd_en, e_rd);
      chk("dst_wr_en", dst_wr_en, e_wr);
      chk("dst_last",  dst_last, e_last);
      chk("done",      done, e_done);
      chk("busy",      busy, e_busy);
      chk("zero_out",  zero_data_out, m_zero);
      h2 = h1;
      h1 = e_rd;
      if (e_rd) m_issued++;
      if (e_wr) begin
        m_written++;
        if (e_last) t_done = cyc + 1;
      end
      if (e_done) m_active = 0;
      else if (!m_active && start) begin
        m_active  = 1;
        t_start   = cyc;
        m_total   = int'(cfg_col) * int'(cfg_row) * int'(cfg_ch_grp);
        m_issued  = 0;
        m_written = 0;
        m_zero    = cfg_zero;
        t_done    = (m_total == 0) ? cyc + 1 : -1;
      end
    end
  end

  // Call right after posedge+#1; runs one tile with per-offset stall masks.
  task automatic run_tile(input string nm, input logic [7:0] z, input int c, input int r,
                          input int g, input logic [63:0] emask, input logic [63:0] amask,
                          input int restart_off, input int exp_wr, input int exp_last_off,
                          input int exp_done_off);
    int wr = 0, last_off = -1, done_off = -1;
    cfg_zero = z; cfg_col = 12'(c); cfg_row = 12'(r); cfg_ch_grp = 10'(g);
    start = 1'b1;
    for (int off = 0; off < 64 && done_off < 0; off++) begin
      if (off > 0) start = 1'b0;
      if (off == restart_off) begin
        start = 1'b1; cfg_zero = 8'h99; cfg_col = 12'd2; cfg_row = 12'd1;
      end
      src_empty       = emask[off];
      dst_almost_full = amask[off];
      @(negedge clk);
      if (dst_wr_en) wr++;
      if (dst_last)  last_off = off;
      if (done)      done_off = off;
      @(posedge clk); #1;
    end
    start = 1'b0; src_empty = 1'b0; dst_almost_full = 1'b0;
    chk({nm, "_writes"},   wr, exp_wr);
    chk({nm, "_last_off"}, last_off, exp_last_off);
    chk({nm, "_done_off"}, done_off, exp_done_off);
  endtask

  initial begin
    int wr;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_tile("basic",   8'd5, 4, 2, 1, 64'h0,  64'h0,   -1, 8, 11, 12);
    run_tile("src_gap", 8'd5, 4, 2, 1, 64'h70, 64'h0,   -1, 8, 14, 15);
    run_tile("dst_af",  8'd5, 4, 2, 1, 64'h0,  64'hFC0, -1, 8, 17, 18);
    run_tile("empty",   8'd3, 0, 2, 1, 64'h0,  64'h0,   -1, 0, -1, 1);
    run_tile("restart", 8'd5, 4, 2, 1, 64'h0,  64'h0,    5, 8, 11, 12);
    run_tile("multi",   8'd7, 3, 2, 2, 64'h0,  64'h0,   -1, 12, 15, 16);

    // Reset with two beats in flight (offset 5: issues at 3 and 4 still in the pipe).
    cfg_zero = 8'd7; cfg_col = 12'd4; cfg_row = 12'd2; cfg_ch_grp = 10'd1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_wr",   dst_wr_en, 0);
    chk("async_rst_rd",   src_rd_en, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wr = 0;
    repeat (5) begin
      @(negedge clk);
      if (dst_wr_en) wr++;
    end
    chk("post_rst_writes", wr, 0);
    @(posedge clk); #1;
    run_tile("single", 8'd1, 1, 1, 1, 64'h0, 64'h0, -1, 1, 4, 5);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
